// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side end of the multiplexed controller<->memory bus.
// Decodes address and burst-data phases from the controller, drives a
// single-port synchronous BRAM, and returns read data plus a held completion
// response on the memory->controller half of the bus.
module mem_bus_responder #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned BURST  = 8
) (
   input  logic              clk,
   input  logic              rst,
   // controller -> memory
   input  logic [31:0]       address_data_bus_c_to_m,
   input  logic              address_on_c_to_m,
   input  logic              data_on_c_to_m,
   input  logic              read_en_c_to_m,
   input  logic              write_en_c_to_m,
   input  logic              resp_c_to_m,
   // memory -> controller
   output logic [31:0]       address_data_bus_m_to_c,
   output logic              address_on_m_to_c,
   output logic              data_on_m_to_c,
   output logic              read_en_m_to_c,
   output logic              write_en_m_to_c,
   output logic              resp_m_to_c,
   output logic              proto_err,
   // BRAM port
   output logic              bram_ena,
   output logic              bram_wea,
   output logic [ADDR_W-1:0] bram_addra,
   output logic [31:0]       bram_dina,
   input  logic [31:0]       bram_douta
);

   // Word counter width and the burst-aligned part of the word address.
   localparam int unsigned CNT_W = $clog2(BURST);
   localparam int unsigned HI_W  = ADDR_W - CNT_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [HI_W-1:0]  base_hi_q, base_hi_d;   // aligned base, low burst bits implied 0
   logic [CNT_W-1:0] cnt_q, cnt_d;           // WR: next word; RD: next word to issue
   logic             rd_ena_q, rd_ena_d;     // BRAM read issue this cycle
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;  // BRAM read address this cycle
   logic             rvalid_q, rvalid_d;     // BRAM read data returns this cycle
   logic             resp_q, resp_d;
   logic             perr_q, perr_d;

   logic [HI_W-1:0]  req_hi_c;
   logic             one_dir_c;
   logic             wr_beat_c;

   // Address-phase decode: word address = byte address >> 2, offset in burst dropped.
   assign req_hi_c  = address_data_bus_c_to_m[ADDR_W+1:CNT_W+2];
   assign one_dir_c = read_en_c_to_m ^ write_en_c_to_m;
   assign wr_beat_c = (state_q == ST_WR) && data_on_c_to_m;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_hi_q <= '0;
         cnt_q     <= '0;
         rd_ena_q  <= 1'b0;
         rd_addr_q <= '0;
         rvalid_q  <= 1'b0;
         resp_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_hi_q <= base_hi_d;
         cnt_q     <= cnt_d;
         rd_ena_q  <= rd_ena_d;
         rd_addr_q <= rd_addr_d;
         rvalid_q  <= rvalid_d;
         resp_q    <= resp_d;
         perr_q    <= perr_d;
      end
   end

   // Next-state logic: address decode, write beats, pipelined read issue/return.
   always_comb begin
      state_d   = state_q;
      base_hi_d = base_hi_q;
      cnt_d     = cnt_q;
      rd_ena_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      rvalid_d  = rd_ena_q;
      resp_d    = resp_q;
      perr_d    = perr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (address_on_c_to_m) begin
               if (one_dir_c) begin
                  base_hi_d = req_hi_c;
                  cnt_d     = '0;
                  if (read_en_c_to_m) begin
                     // First read issues in the cycle right after the address phase.
                     state_d   = ST_RD;
                     rd_ena_d  = 1'b1;
                     rd_addr_d = {req_hi_c, CNT_W'(0)};
                     cnt_d     = CNT_W'(1);
                  end else begin
                     state_d = ST_WR;
                  end
               end else begin
                  perr_d = 1'b1;
               end
            end
            if (data_on_c_to_m) begin
               perr_d = 1'b1;
            end
         end
         ST_WR: begin
            if (data_on_c_to_m) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  resp_d  = 1'b1;
               end
            end
         end
         ST_RD: begin
            // cnt wraps to 0 once every word has been issued.
            if (rd_ena_q) begin
               rd_ena_d  = (cnt_q != '0);
               rd_addr_d = {base_hi_q, cnt_q};
               cnt_d     = cnt_q + CNT_W'(1);
            end
            if (rvalid_q && !rd_ena_q) begin
               state_d = ST_DONE;
               resp_d  = 1'b1;
            end
         end
         ST_DONE: begin
            if (resp_c_to_m) begin
               state_d = ST_IDLE;
               resp_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (address_on_c_to_m && (state_q != ST_IDLE)) begin
         perr_d = 1'b1;
      end
   end

   // BRAM port: write path straight from the bus, read path from registers.
   always_comb begin
      bram_ena   = 1'b0;
      bram_wea   = 1'b0;
      bram_addra = '0;
      bram_dina  = '0;
      if (wr_beat_c) begin
         bram_ena   = 1'b1;
         bram_wea   = 1'b1;
         bram_addra = {base_hi_q, cnt_q};
         bram_dina  = address_data_bus_c_to_m;
      end else if (rd_ena_q) begin
         bram_ena   = 1'b1;
         bram_addra = rd_addr_q;
      end
   end

   assign address_data_bus_m_to_c = rvalid_q ? bram_douta : 32'h0;
   assign data_on_m_to_c          = rvalid_q;
   assign address_on_m_to_c       = 1'b0;
   assign read_en_m_to_c          = 1'b0;
   assign write_en_m_to_c         = 1'b0;
   assign resp_m_to_c             = resp_q;
   assign proto_err               = perr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder with a behavioural synchronous BRAM.
module tb_mem_bus_responder;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned BURST  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       bus_c;
   logic              addr_on, data_on, rd_en, wr_en, resp_c;
   logic [31:0]       bus_m;
   logic              addr_on_m, data_on_m, rd_en_m, wr_en_m, resp_m, perr;
   logic              bram_ena, bram_wea;
   logic [ADDR_W-1:0] bram_addra;
   logic [31:0]       bram_dina, bram_douta;

   mem_bus_responder #(.ADDR_W(ADDR_W), .BURST(BURST)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .address_data_bus_c_to_m (bus_c),
      .address_on_c_to_m       (addr_on),
      .data_on_c_to_m          (data_on),
      .read_en_c_to_m          (rd_en),
      .write_en_c_to_m         (wr_en),
      .resp_c_to_m             (resp_c),
      .address_data_bus_m_to_c (bus_m),
      .address_on_m_to_c       (addr_on_m),
      .data_on_m_to_c          (data_on_m),
      .read_en_m_to_c          (rd_en_m),
      .write_en_m_to_c         (wr_en_m),
      .resp_m_to_c             (resp_m),
      .proto_err               (perr),
      .bram_ena                (bram_ena),
      .bram_wea                (bram_wea),
      .bram_addra              (bram_addra),
      .bram_dina               (bram_dina),
      .bram_douta              (bram_douta)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural BRAM with a bench-side preload port.
   logic [31:0]       mem [0:255];
   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_a  = '0;
   logic [31:0]       pre_d  = '0;
   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (bram_ena) begin
         if (bram_wea) mem[bram_addra] <= bram_dina;
         else          bram_douta      <= mem[bram_addra];
      end
   end

   // Scoreboard state.
   logic [31:0] exp_mem [0:255];
   logic [31:0] exp_rd_data[$];
   int          exp_rd_cyc[$];
   int          exp_resp_cyc[$];
   logic [31:0] exp_wr_addr[$];
   logic [31:0] exp_wr_data[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents data, a BRAM write or a response.
   logic        resp_prev = 1'b0;
   logic [31:0] m_val;
   int          m_cyc;
   always @(negedge clk) begin
      if (data_on_m) begin
         if (exp_rd_data.size() == 0) unexpected("rdata");
         else begin
            m_val = exp_rd_data.pop_front();
            m_cyc = exp_rd_cyc.pop_front();
            check("rdata", bus_m, m_val);
            check("rdata_cycle", 32'(cyc), 32'(m_cyc));
         end
      end else begin
         check("bus_idle_zero", bus_m, 32'h0);
      end
      if (bram_ena && bram_wea) begin
         if (exp_wr_addr.size() == 0) unexpected("bram_write");
         else begin
            m_val = exp_wr_addr.pop_front();
            check("wr_addr", 32'(bram_addra), m_val);
            m_val = exp_wr_data.pop_front();
            check("wr_data", bram_dina, m_val);
         end
      end
      if (resp_m && !resp_prev) begin
         if (exp_resp_cyc.size() == 0) unexpected("resp_rise");
         else begin
            m_cyc = exp_resp_cyc.pop_front();
            check("resp_cycle", 32'(cyc), 32'(m_cyc));
         end
      end
      resp_prev = resp_m;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      addr_on = 1'b0; data_on = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      resp_c  = 1'b0; bus_c   = 32'h0;
   endtask

   // Write nwords of d0, d0+1, ... ; base is the hand-computed aligned word address.
   task automatic write_burst(input logic [31:0] addr, input int base, input logic [31:0] d0,
                              input int nwords, input int max_gap);
      int gaps;
      addr_on = 1'b1; wr_en = 1'b1; bus_c = addr;
      tick();
      drive_idle();
      for (int i = 0; i < nwords; i++) begin
         gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gaps; g++) begin
            bus_c = 32'hDEAD_BEEF;
            tick();
         end
         data_on = 1'b1;
         bus_c   = d0 + 32'(i);
         exp_wr_addr.push_back(32'(base + i));
         exp_wr_data.push_back(d0 + 32'(i));
         exp_mem[base + i] = d0 + 32'(i);
         if (i == BURST - 1) exp_resp_cyc.push_back(cyc + 1);
         tick();
         drive_idle();
      end
   endtask

   // Read burst; optional stray address phase mid_at cycles after the request.
   task automatic read_burst(input logic [31:0] addr, input int base, input int mid_at);
      int t;
      t = cyc;
      addr_on = 1'b1; rd_en = 1'b1; bus_c = addr;
      for (int i = 0; i < BURST; i++) begin
         exp_rd_data.push_back(exp_mem[base + i]);
         exp_rd_cyc.push_back(t + 2 + i);
      end
      exp_resp_cyc.push_back(t + BURST + 2);
      tick();
      drive_idle();
      if (mid_at > 0) begin
         repeat (mid_at - 1) tick();
         addr_on = 1'b1; rd_en = 1'b1; bus_c = 32'h80;
         tick();
         drive_idle();
      end
   endtask

   // Wait (bounded) for the response, hold the ack off for delay cycles, then ack.
   task automatic ack(input int delay);
      int n;
      n = 0;
      while (!resp_m && n < 40) begin
         tick();
         n++;
      end
      if (!resp_m) begin
         unexpected("resp_timeout");
         return;
      end
      for (int i = 0; i < delay; i++) begin
         check("resp_held", 32'(resp_m), 32'h1);
         tick();
      end
      resp_c = 1'b1;
      check("resp_at_ack", 32'(resp_m), 32'h1);
      tick();
      resp_c = 1'b0;
      check("resp_cleared", 32'(resp_m), 32'h0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_resp"},     32'(resp_m),     32'h0);
      check({tag, "_data_on"},  32'(data_on_m),  32'h0);
      check({tag, "_bus_m"},    bus_m,           32'h0);
      check({tag, "_ena"},      32'(bram_ena),   32'h0);
      check({tag, "_wea"},      32'(bram_wea),   32'h0);
      check({tag, "_addra"},    32'(bram_addra), 32'h0);
      check({tag, "_dina"},     bram_dina,       32'h0);
      check({tag, "_perr"},     32'(perr),       32'h0);
      check({tag, "_tied"},     32'({addr_on_m, rd_en_m, wr_en_m}), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      // Preload words 0..7 with 0xA0..0xA7 while in reset.
      for (int i = 0; i < 8; i++) begin
         pre_we = 1'b1; pre_a = ADDR_W'(i); pre_d = 32'hA0 + 32'(i);
         exp_mem[i] = 32'hA0 + 32'(i);
         tick();
      end
      pre_we = 1'b0;
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // Gap-free write to 0x40 -> words 16..23.
      write_burst(32'h40, 16, 32'h11, 8, 0);
      ack(1);
      for (int i = 0; i < 8; i++) check("mem_after_write", mem[16 + i], 32'h11 + 32'(i));

      // Read it back with a delayed ack.
      read_burst(32'h40, 16, 0);
      ack(3);

      // Unaligned write with gaps, then unaligned read of the same burst.
      write_burst(32'h5C, 16, 32'h21, 8, 2);
      ack(0);
      tick();
      read_burst(32'h50, 16, 0);
      ack(2);

      // Illegal address phase, then a read with a stray address phase mid-burst.
      check("perr_before", 32'(perr), 32'h0);
      addr_on = 1'b1; rd_en = 1'b1; wr_en = 1'b1; bus_c = 32'h40;
      tick();
      drive_idle();
      check("perr_set", 32'(perr), 32'h1);
      check("both_en_ignored", 32'(bram_ena), 32'h0);
      tick();
      check("both_en_no_resp", 32'(resp_m), 32'h0);
      read_burst(32'h40, 16, 3);
      ack(1);
      check("perr_sticky", 32'(perr), 32'h1);

      // Reset after 4 of 8 write words.
      write_burst(32'h0, 0, 32'hC0, 4, 0);
      rst = 1'b1;
      #1;
      check_outputs_zero("abort");
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) check("abort_written", mem[i], 32'hC0 + 32'(i));
      for (int i = 4; i < 8; i++) check("abort_untouched", mem[i], 32'hA0 + 32'(i));

      // Post-abort read, then a back-to-back read right after a first-cycle ack.
      read_burst(32'h0, 0, 0);
      ack(0);
      read_burst(32'h40, 16, 0);
      ack(2);

      repeat (5) tick();
      check("rd_queue_empty",   32'(exp_rd_data.size()),  32'h0);
      check("wr_queue_empty",   32'(exp_wr_addr.size()),  32'h0);
      check("resp_queue_empty", 32'(exp_resp_cyc.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
